// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the core load/store path and a DMA/debug loader.
// Optional macro DMEM_ARB_LOCK_EN enables bounded DMA lock bursts; default build uses fixed core priority.
module dmem_arbiter #(
  parameter int AW            = 16,
  parameter int DW            = 16,
  parameter int RD_LAT        = 1,
  parameter int DMA_MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_stall,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_lock,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rd
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CORE   = 2'd1;
  localparam logic [1:0] ST_DMA    = 2'd2;
  localparam logic [3:0] BURST_MAX = 4'(DMA_MAX_BURST);

  logic [1:0]        state_q, state_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0] pipe_id_q, pipe_id_d;
  logic [DW-1:0]     c_rdata_q, d_rdata_q;
  logic              lock_hold_s;
  logic              c_gnt_s, d_gnt_s;

`ifdef DMEM_ARB_LOCK_EN
  // A DMA lock only persists from the DMA state, and only until the burst budget is spent.
  assign lock_hold_s = (state_q == ST_DMA) & d_lock & d_req & (burst_cnt_q < BURST_MAX);
`else
  logic unused_lock_s;
  assign unused_lock_s = ^{d_lock, state_q};
  assign lock_hold_s   = 1'b0;
`endif

  // Grant selection; grants are forced low while reset is asserted.
  always_comb begin
    c_gnt_s = rst & c_req & ~lock_hold_s;
    d_gnt_s = rst & d_req & ~(c_req & ~lock_hold_s);
  end

  assign c_gnt   = c_gnt_s;
  assign d_gnt   = d_gnt_s;
  assign c_stall = rst & c_req & ~c_gnt_s;

  // Memory port mux follows the granted requester.
  always_comb begin
    if (c_gnt_s) begin
      mem_a  = c_addr;
      mem_wd = c_wdata;
      mem_we = c_we;
      mem_re = ~c_we;
    end else if (d_gnt_s) begin
      mem_a  = d_addr;
      mem_wd = d_wdata;
      mem_we = d_we;
      mem_re = ~d_we;
    end else begin
      mem_a  = {AW{1'b0}};
      mem_wd = {DW{1'b0}};
      mem_we = 1'b0;
      mem_re = 1'b0;
    end
  end

  // Ownership state and DMA burst counter next-state.
  always_comb begin
    if (c_gnt_s) begin
      state_d = ST_CORE;
    end else if (d_gnt_s) begin
      state_d = ST_DMA;
    end else begin
      state_d = ST_IDLE;
    end
    if (c_gnt_s || !c_req) begin
      burst_cnt_d = 4'd0;
    end else if (d_gnt_s && (burst_cnt_q < BURST_MAX)) begin
      burst_cnt_d = burst_cnt_q + 4'd1;
    end else begin
      burst_cnt_d = burst_cnt_q;
    end
  end

  // Response pipeline: stage 0 takes the new read, the last stage lines up with mem_rd.
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_id_d     = pipe_id_q;
    pipe_vld_d[0] = mem_re;
    pipe_id_d[0]  = d_gnt_s;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
    end
  end

  assign c_rvalid = pipe_vld_q[RD_LAT-1] & ~pipe_id_q[RD_LAT-1];
  assign d_rvalid = pipe_vld_q[RD_LAT-1] &  pipe_id_q[RD_LAT-1];
  assign c_rdata  = c_rvalid ? mem_rd : c_rdata_q;
  assign d_rdata  = d_rvalid ? mem_rd : d_rdata_q;

  // State, counter, pipeline and held read data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= 4'd0;
      pipe_vld_q  <= {RD_LAT{1'b0}};
      pipe_id_q   <= {RD_LAT{1'b0}};
      c_rdata_q   <= {DW{1'b0}};
      d_rdata_q   <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_id_q   <= pipe_id_d;
      c_rdata_q   <= c_rdata;
      d_rdata_q   <= d_rdata;
    end
  end

endmodule
